hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. Tracks destination register and remaining result latency (Tnew) for instructions in the E, M and W stages, and compares them against the operand demand time (Tuse) of the instruction in D. Produces the stall signal and the select codes for the D-stage and E-stage forwarding muxes (4-input and 3-input 32-bit muxes). Also owns the multiply/divide busy counter that blocks HI/LO accesses.

---
 rtl/hazard_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller: Tnew/Tuse stall detection, D/E forwarding selects, mult/div busy counter.
// Latency: outputs combinational from state and D inputs; state advances every edge.
// Backpressure: stall freezes PC and F/D and bubbles E; E/M/W never hold.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       md_busy
);

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    logic [4:0] e_rs, e_rt, e_wa, m_wa, w_wa;
    logic [1:0] e_tnew, m_tnew;
    logic [3:0] md_cnt;
    logic       stall_rs, stall_rt, stall_md;

    function automatic logic src_stall(
        input logic [4:0] src, input logic [1:0] tuse,
        input logic [4:0] ewa, input logic [1:0] etn,
        input logic [4:0] mwa, input logic [1:0] mtn
    );
        return (src != 5'd0) && (tuse != 2'd3) &&
               (((ewa == src) && (etn > tuse)) || ((mwa == src) && (mtn > tuse)));
    endfunction

    // The youngest matching stage owns the register; if its result is not ready
    // it selects nothing rather than letting an older, stale stage forward.
    function automatic logic [1:0] sel_d(
        input logic [4:0] src,
        input logic [4:0] ewa, input logic [1:0] etn,
        input logic [4:0] mwa, input logic [1:0] mtn,
        input logic [4:0] wwa
    );
        if (src == 5'd0)     return 2'b00;
        else if (ewa == src) return (etn == 2'd0) ? 2'b01 : 2'b00;
        else if (mwa == src) return (mtn == 2'd0) ? 2'b10 : 2'b00;
        else if (wwa == src) return 2'b11;
        else                 return 2'b00;
    endfunction

    function automatic logic [1:0] sel_e(
        input logic [4:0] src,
        input logic [4:0] mwa, input logic [1:0] mtn,
        input logic [4:0] wwa
    );
        if (src == 5'd0)     return 2'b00;
        else if (mwa == src) return (mtn == 2'd0) ? 2'b01 : 2'b00;
        else if (wwa == src) return 2'b10;
        else                 return 2'b00;
    endfunction

    assign stall_rs = src_stall(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
    assign stall_rt = src_stall(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
    assign md_busy  = (md_cnt != 4'd0);
    assign stall_md = d_md_use && md_busy;
    assign stall    = stall_rs | stall_rt | stall_md;

    assign fwd_d_rs = sel_d(d_rs, e_wa, e_tnew, m_wa, m_tnew, w_wa);
    assign fwd_d_rt = sel_d(d_rt, e_wa, e_tnew, m_wa, m_tnew, w_wa);
    assign fwd_e_rs = sel_e(e_rs, m_wa, m_tnew, w_wa);
    assign fwd_e_rt = sel_e(e_rt, m_wa, m_tnew, w_wa);

    always_ff @(posedge clk) begin
        if (reset) begin
            e_rs   <= 5'd0;
            e_rt   <= 5'd0;
            e_wa   <= 5'd0;
            e_tnew <= 2'd0;
            m_wa   <= 5'd0;
            m_tnew <= 2'd0;
            w_wa   <= 5'd0;
            md_cnt <= 4'd0;
        end else begin
            if (stall) begin
                e_rs   <= 5'd0;
                e_rt   <= 5'd0;
                e_wa   <= 5'd0;
                e_tnew <= 2'd0;
            end else begin
                e_rs   <= d_rs;
                e_rt   <= d_rt;
                e_wa   <= d_wa;
                e_tnew <= d_tnew;
            end
            m_wa   <= e_wa;
            m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
            w_wa   <= m_wa;
            if (d_md_start && !stall)
                md_cnt <= d_md_div ? DIV_LD : MULT_LD;
            else if (md_cnt != 4'd0)
                md_cnt <= md_cnt - 4'd1;
        end
    end

endmodule
